// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the data-memory responder and its bus interface.
//   WORD_W     : data/address word width (32)
//   wait_cnt_t : 4-bit wait-state counter type
//   state_t    : responder FSM states (IDLE, WAIT, RESP)
//   addr_err   : flags a misaligned or out-of-range byte address
// -----------------------------------------------------------------------------
package mem_if_pkg;

    localparam int WORD_W = 32;

    typedef logic [3:0] wait_cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A word access must be 4-byte aligned and its word index must fall
    // inside the array.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                      input int unsigned       depth_words);
        logic [WORD_W-1:0] word_idx;
        word_idx = {2'b00, addr[WORD_W-1:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth_words);
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// -----------------------------------------------------------------------------
// dm_responder_if
// Load/store request bus between the core (master) and the data memory
// responder (slave).
//   req   : access request, held until ready      (master -> slave)
//   we    : 1 = store, 0 = load                    (master -> slave)
//   addr  : byte address                           (master -> slave)
//   wdata : store data                             (master -> slave)
//   rdata : load data / echoed store data          (slave -> master)
//   ready : one-cycle response strobe              (slave -> master)
//   err   : access misaligned or out of range      (slave -> master)
//   busy  : access in progress, stalls the PC      (slave -> master)
// -----------------------------------------------------------------------------
interface dm_responder_if;
    import mem_if_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ready;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err, busy
    );

endinterface

// File: rtl/dm_array.sv
// -----------------------------------------------------------------------------
// dm_array
// DEPTH_WORDS x 32-bit word storage with a synchronous write port and a
// combinational read of the same index. Reset clears every word.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear of all words
//   we    : write enable
//   idx   : word index for both read and write
//   wdata : write data
//   rdata : combinational read data at idx
// -----------------------------------------------------------------------------
module dm_array
    import mem_if_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
// Word-addressed data memory with a req/ready handshake and WAIT_STATES
// extra cycles of latency. Misaligned or out-of-range accesses respond with
// err = 1, rdata = 0 and never modify the array.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (also clears the array)
//   bus   : dm_responder_if slave port (req/we/addr/wdata in,
//           rdata/ready/err/busy out)
// -----------------------------------------------------------------------------
module dm_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);

    localparam int        IDX_W    = $clog2(DEPTH_WORDS);
    localparam wait_cnt_t CNT_INIT = wait_cnt_t'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t            state_q, state_d;
    wait_cnt_t         cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              acc_we;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic              enter_resp;
    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;

    // With zero wait states the array is accessed on the acceptance edge
    // itself, before the latch holds anything, so the live bus is used in
    // IDLE and the latched copy everywhere else.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_we    = bus.we;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
        end
        acc_err = addr_err(acc_addr, DEPTH_WORDS);
        acc_idx = acc_addr[IDX_W+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - wait_cnt_t'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Store commit, load capture and the ready strobe all share the edge
    // that enters RESP, so a following load observes the new data.
    always_comb begin
        enter_resp = (state_d == RESP) && (state_q != RESP);
        arr_we     = enter_resp && acc_we && !acc_err;
        ready_d    = enter_resp;
        busy_d     = (state_d == WAIT);
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (enter_resp) begin
            err_d = acc_err;
            if (acc_err) begin
                rdata_d = '0;
            end else if (acc_we) begin
                rdata_d = acc_wdata;
            end else begin
                rdata_d = arr_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    dm_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
// Directed bench for dm_responder: one instance with default wait states,
// one with WAIT_STATES = 0 driven with req held high.
// -----------------------------------------------------------------------------
module tb_dm_responder;

    logic clk;
    logic reset;

    int n_chk;
    int n_pass;

    dm_responder_if b0 ();
    dm_responder_if b1 ();

    dm_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    dm_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (0)
    ) u_dut_ws0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One access on the default instance. Inputs are scrambled once the
    // request is accepted, so the response must come from latched values.
    task automatic acc0(input  logic        w,
                        input  logic [31:0] a,
                        input  logic [31:0] d,
                        output logic [31:0] rd,
                        output logic        e,
                        output int          lat,
                        output int          busy_n,
                        output time         t_rdy);
        b0.req   = 1'b1;
        b0.we    = w;
        b0.addr  = a;
        b0.wdata = d;
        rd     = '0;
        e      = 1'b0;
        lat    = 0;
        busy_n = 0;
        t_rdy  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                b0.we    = ~w;
                b0.addr  = 32'hFFFF_FFF3;
                b0.wdata = ~d;
            end
            if (b0.busy) busy_n++;
            if (b0.ready) begin
                lat   = i;
                rd    = b0.rdata;
                e     = b0.err;
                t_rdy = $time;
                break;
            end
        end
        b0.req = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_one_cycle", {31'd0, b0.ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          bn;
        time         t0;
        time         t1;
        logic        rdy_seen;

        n_chk  = 0;
        n_pass = 0;
        b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
        b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0;
        reset  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, b0.ready}, 32'd0);
        chk("rst_busy",  {31'd0, b0.busy},  32'd0);
        chk("rst_err",   {31'd0, b0.err},   32'd0);
        chk("rst_rdata", b0.rdata,          32'd0);
        reset = 1'b0;

        // Load from a freshly cleared array
        acc0(1'b0, 32'h0000_0010, 32'h0, rd, e, lat, bn, t0);
        chk("ld10_lat",   lat,          32'd3);
        chk("ld10_rdata", rd,           32'd0);
        chk("ld10_err",   {31'd0, e},   32'd0);
        chk("ld10_busy",  bn,           32'd2);

        // Store then load back-to-back
        acc0(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, rd, e, lat, bn, t0);
        chk("st40_lat",   lat,        32'd3);
        chk("st40_rdata", rd,         32'hDEAD_BEEF);
        chk("st40_err",   {31'd0, e}, 32'd0);
        acc0(1'b0, 32'h0000_0040, 32'h0, rd, e, lat, bn, t1);
        chk("ld40_lat",   lat,               32'd3);
        chk("ld40_rdata", rd,                32'hDEAD_BEEF);
        chk("ld40_err",   {31'd0, e},        32'd0);
        chk("st_ld_gap",  32'(t1 - t0),      32'd40);

        // Misaligned store must not touch the array
        acc0(1'b1, 32'h0000_0042, 32'h1234_5678, rd, e, lat, bn, t0);
        chk("st42_err",   {31'd0, e}, 32'd1);
        chk("st42_rdata", rd,         32'd0);
        acc0(1'b0, 32'h0000_0040, 32'h0, rd, e, lat, bn, t0);
        chk("ld40b_rdata", rd,         32'hDEAD_BEEF);
        chk("ld40b_err",   {31'd0, e}, 32'd0);
        chk("rdata_hold",  b0.rdata,   32'hDEAD_BEEF);
        chk("err_hold",    {31'd0, b0.err}, 32'd0);

        // Out of range: word 1024
        acc0(1'b0, 32'h0000_1000, 32'h0, rd, e, lat, bn, t0);
        chk("ld1000_err",   {31'd0, e}, 32'd1);
        chk("ld1000_rdata", rd,         32'd0);

        // Last valid word
        acc0(1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, rd, e, lat, bn, t0);
        chk("stffc_err",   {31'd0, e}, 32'd0);
        acc0(1'b0, 32'h0000_0FFC, 32'h0, rd, e, lat, bn, t0);
        chk("ldffc_rdata", rd,         32'h0BAD_CAFE);
        chk("ldffc_err",   {31'd0, e}, 32'd0);

        // Reset in the middle of a store
        b0.req   = 1'b1;
        b0.we    = 1'b1;
        b0.addr  = 32'h0000_0020;
        b0.wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, b0.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, b0.ready}, 32'd0);
        chk("mid_rst_busy",  {31'd0, b0.busy},  32'd0);
        chk("mid_rst_err",   {31'd0, b0.err},   32'd0);
        chk("mid_rst_rdata", b0.rdata,          32'd0);
        b0.req   = 1'b0;
        rdy_seen = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (b0.ready) rdy_seen = 1'b1;
            if (i == 2) reset = 1'b0;
        end
        chk("mid_no_ready", {31'd0, rdy_seen}, 32'd0);
        acc0(1'b0, 32'h0000_0020, 32'h0, rd, e, lat, bn, t0);
        chk("ld20_rdata", rd,         32'd0);
        chk("ld20_err",   {31'd0, e}, 32'd0);
        acc0(1'b0, 32'h0000_0040, 32'h0, rd, e, lat, bn, t0);
        chk("ld40_cleared", rd, 32'd0);

        // Zero wait states with req held high: store twice, then load twice
        b1.req   = 1'b1;
        b1.we    = 1'b1;
        b1.addr  = 32'h0000_0008;
        b1.wdata = 32'hA5A5_0001;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            chk("ws0_ready", {31'd0, b1.ready}, 32'(i % 2));
            chk("ws0_busy",  {31'd0, b1.busy},  32'd0);
            if ((i % 2) == 1) begin
                chk("ws0_rdata", b1.rdata, 32'hA5A5_0001);
                chk("ws0_err",   {31'd0, b1.err}, 32'd0);
            end
            if (i == 4) begin
                b1.we    = 1'b0;
                b1.wdata = 32'h0;
            end
        end
        b1.req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
